// File: rtl/condition_unit.sv
// Condition-code unit: registered NZCV flags, condition evaluation, gated write enables,
// and a small LIFO for saving/restoring flags.
module condition_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] flags_in,
  input  logic [3:0] cond,
  input  logic       instr_valid,
  input  logic       flag_we,
  input  logic       reg_we_in,
  input  logic       mem_we_in,
  input  logic       pc_src_in,
  input  logic       push,
  input  logic       pop,
  output logic       reg_we,
  output logic       mem_we,
  output logic       pc_src,
  output logic       cond_ex,
  output logic [3:0] flags,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [3:0]    stack_q [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx;
  logic          n_f, z_f, c_f, v_f;
  logic          push_ok, pop_ok, upd;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'd0:    cond_ex = z_f;
      4'd1:    cond_ex = ~z_f;
      4'd2:    cond_ex = c_f;
      4'd3:    cond_ex = ~c_f;
      4'd4:    cond_ex = n_f;
      4'd5:    cond_ex = ~n_f;
      4'd6:    cond_ex = v_f;
      4'd7:    cond_ex = ~v_f;
      4'd8:    cond_ex = c_f & ~z_f;
      4'd9:    cond_ex = ~c_f | z_f;
      4'd10:   cond_ex = (n_f == v_f);
      4'd11:   cond_ex = (n_f != v_f);
      4'd12:   cond_ex = ~z_f & (n_f == v_f);
      4'd13:   cond_ex = z_f | (n_f != v_f);
      4'd14:   cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign reg_we = reg_we_in & cond_ex & instr_valid;
  assign mem_we = mem_we_in & cond_ex & instr_valid;
  assign pc_src = pc_src_in & cond_ex & instr_valid;

  assign stk_empty = (count_q == '0);
  assign stk_full  = (count_q == CW'(DEPTH));

  assign wr_idx = IW'(count_q);
  assign rd_idx = IW'(count_q - CW'(1));

  // Simultaneous push and pop is treated as an error and neither takes effect.
  assign push_ok = push & ~pop & ~stk_full;
  assign pop_ok  = pop & ~push & ~stk_empty;
  assign upd     = instr_valid & flag_we & cond_ex;

  always_comb begin
    err_d   = (push & pop) | (push & ~pop & stk_full) | (pop & ~push & stk_empty);
    count_d = count_q;
    flags_d = flags_q;
    if (push_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok) begin
      count_d = count_q - CW'(1);
    end
    // A restoring pop wins over a flag update in the same cycle.
    if (pop_ok) begin
      flags_d = stack_q[rd_idx];
    end else if (upd) begin
      flags_d = flags_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry contents need no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_q[wr_idx] <= flags_q;
    end
  end

  assign flags   = flags_q;
  assign stk_err = err_q;

endmodule

// File: tb/tb_condition_unit.sv
// Self-checking bench for condition_unit: directed steps plus randomized traffic checked
// against a queue-based behavioural model.
module tb_condition_unit;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] flags_in, cond;
  logic       instr_valid, flag_we, reg_we_in, mem_we_in, pc_src_in, push, pop;
  logic       reg_we, mem_we, pc_src, cond_ex, stk_full, stk_empty, stk_err;
  logic [3:0] flags;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  bit [3:0] flags_m;
  bit       err_m;
  bit [3:0] stk_m[$];

  condition_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .cond(cond),
    .instr_valid(instr_valid), .flag_we(flag_we), .reg_we_in(reg_we_in),
    .mem_we_in(mem_we_in), .pc_src_in(pc_src_in), .push(push), .pop(pop),
    .reg_we(reg_we), .mem_we(mem_we), .pc_src(pc_src), .cond_ex(cond_ex),
    .flags(flags), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  // Odd codes invert the predicate of the preceding even code; 14/15 are always/never.
  function automatic bit ref_cond(input bit [3:0] f, input bit [3:0] c);
    bit n, z, cy, v, p;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cy;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cy && !z;
      3'd5: p = (n == v);
      3'd6: p = !z && (n == v);
      default: return !c[0];
    endcase
    return p ^ c[0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic set_in(input bit iv, input bit fwe, input bit [3:0] fin, input bit [3:0] c,
                        input bit rwi, input bit mwi, input bit pci, input bit pu,
                        input bit po);
    instr_valid = iv; flag_we = fwe; flags_in = fin; cond = c;
    reg_we_in = rwi; mem_we_in = mwi; pc_src_in = pci; push = pu; pop = po;
  endtask

  task automatic model_reset();
    flags_m = 4'b0000;
    err_m   = 1'b0;
    stk_m.delete();
  endtask

  task automatic model_next();
    bit       pass, upd, popped;
    bit [3:0] pv, nf;
    pass   = ref_cond(flags_m, cond);
    upd    = instr_valid && flag_we && pass;
    popped = 1'b0;
    pv     = 4'b0000;
    err_m  = 1'b0;
    if (push && pop) begin
      err_m = 1'b1;
    end else if (push) begin
      if (stk_m.size() == DEPTH) err_m = 1'b1;
      else stk_m.push_back(flags_m);
    end else if (pop) begin
      if (stk_m.size() == 0) err_m = 1'b1;
      else begin
        pv = stk_m.pop_back();
        popped = 1'b1;
      end
    end
    nf = popped ? pv : (upd ? flags_in : flags_m);
    flags_m = nf;
  endtask

  task automatic check_comb(input string tag);
    bit pass;
    pass = ref_cond(flags_m, cond);
    chk({tag, "_cond_ex"}, {7'd0, cond_ex}, {7'd0, pass});
    chk({tag, "_gated"}, {5'd0, reg_we, mem_we, pc_src},
        {5'd0, reg_we_in && pass && instr_valid, mem_we_in && pass && instr_valid,
         pc_src_in && pass && instr_valid});
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_flags"}, {4'd0, flags}, {4'd0, flags_m});
    chk({tag, "_status"}, {5'd0, stk_full, stk_empty, stk_err},
        {5'd0, stk_m.size() == DEPTH, stk_m.size() == 0, err_m});
  endtask

  // Inputs are applied at posedge+1; outputs checked away from the edge.
  task automatic step(input string tag);
    #1;
    check_comb(tag);
    model_next();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic load(input bit [3:0] f);
    set_in(1, 1, f, 4'd14, 0, 0, 0, 0, 0);
    step("load");
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 4'b0000, 4'd0, 1, 1, 1, 0, 0);
    model_reset();
    #3;
    check_state("rst");
    chk("rst_c0", {7'd0, cond_ex}, 8'd0);
    set_in(1, 0, 4'b0000, 4'd14, 1, 0, 1, 0, 0);
    #1;
    chk("rst_c14", {4'd0, cond_ex, reg_we, mem_we, pc_src}, 8'b1101);
    @(posedge clk);
    #1;
    check_state("rst_hold");
    reset_n = 1'b1;

    // Basic update then condition on Z.
    load(4'b0100);
    chk("upd_flags", {4'd0, flags}, 8'b0100);
    set_in(0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 0);
    #1;
    chk("upd_c0", {7'd0, cond_ex}, 8'd1);
    set_in(0, 0, 4'b0000, 4'd1, 0, 0, 0, 0, 0);
    step("upd_c1");

    // Gating with N and V set.
    load(4'b1001);
    set_in(1, 0, 4'b0000, 4'd10, 1, 0, 0, 0, 0);
    #1;
    chk("gate_ge", {7'd0, reg_we}, 8'd1);
    set_in(1, 1, 4'b0110, 4'd11, 1, 1, 1, 0, 0);
    step("gate_lt");
    chk("gate_hold", {4'd0, flags}, 8'b1001);

    // Full condition sweep.
    for (int f = 0; f < 16; f++) begin
      load(4'(f));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        chk($sformatf("sweep_f%0d_c%0d", f, c), {7'd0, cond_ex}, {7'd0, ref_cond(4'(f), 4'(c))});
      end
    end

    // Stack fill, overflow, drain, underflow.
    load(4'b0001);
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 1, 0);
    step("push1");
    load(4'b0010);
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 1, 0);
    step("push2");
    chk("full", {7'd0, stk_full}, 8'd1);
    step("push_ovf");
    chk("ovf_err", {7'd0, stk_err}, 8'd1);
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 0, 0);
    step("err_clear");
    chk("err_clr", {7'd0, stk_err}, 8'd0);
    load(4'b1100);
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 0, 1);
    step("pop1");
    chk("pop1_val", {4'd0, flags}, 8'b0010);
    step("pop2");
    chk("pop2_val", {4'd0, flags, stk_empty}, {4'd0, 4'b0001, 1'b1});
    step("pop_unf");
    chk("unf", {4'd0, flags, stk_err}, {4'd0, 4'b0001, 1'b1});

    // Collisions.
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 1, 0);
    step("c_push");
    set_in(1, 1, 4'b0110, 4'd14, 0, 0, 0, 1, 1);
    step("c_pushpop");
    chk("c_pp", {3'd0, flags, stk_err}, {3'd0, 4'b0110, 1'b1});
    set_in(1, 1, 4'b1111, 4'd14, 0, 0, 0, 0, 1);
    step("c_popupd");
    chk("c_pu", {4'd0, flags}, 8'b0001);
    set_in(1, 1, 4'b1110, 4'd14, 0, 0, 0, 1, 0);
    step("c_pushupd");
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 0, 1);
    step("c_popchk");
    chk("c_stored", {4'd0, flags}, 8'b0001);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
             4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      step("rnd");
    end

    // Asynchronous reset between edges with one entry and flags 1010.
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) step("drain");
    load(4'b1010);
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 1, 0);
    step("ar_push");
    set_in(0, 0, 4'b0000, 4'd15, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_now", {2'd0, flags, stk_empty, stk_err}, {2'd0, 4'b0000, 1'b1, 1'b0});
    model_reset();
    push = 1'b1;
    #1;
    reset_n = 1'b1;
    #1;
    chk("ar_deassert", {3'd0, flags, stk_empty}, {3'd0, 4'b0000, 1'b1});
    step("ar_first_push");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/condition_unit.md
CONDITION_UNIT -- requirements
Module: condition_unit

Interface
REQ-001 Parameter: DEPTH, 2, number of entries in the saved-flags stack (1..8).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 flags_in  input  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-005 cond  input  4  condition field of the current instruction.
REQ-006 instr_valid  input  1  current-cycle instruction is valid.
REQ-007 flag_we  input  1  instruction requests a flag update (S-bit).
REQ-008 reg_we_in, mem_we_in, pc_src_in  input  1 each  ungated decoder enables.
REQ-009 push  input  1  save current flags to the stack.
REQ-010 pop  input  1  restore flags from the stack.
REQ-011 reg_we, mem_we, pc_src  output  1 each  condition-gated enables.
REQ-012 cond_ex  output  1  condition passed.
REQ-013 flags  output  4  registered {N,Z,C,V}.
REQ-014 stk_full, stk_empty  output  1 each  stack occupancy status.
REQ-015 stk_err  output  1  registered one-cycle error pulse.

Function
REQ-016 cond_ex SHALL be combinational from registered flags: 0 Z; 1 ~Z; 2 C; 3 ~C; 4 N; 5 ~N; 6 V; 7 ~V; 8 C&~Z; 9 ~C|Z; 10 N==V; 11 N!=V; 12 ~Z&(N==V); 13 Z|(N!=V); 14 1; 15 0.
REQ-017 Each gated enable SHALL equal its _in input AND cond_ex AND instr_valid, combinationally, zero added latency.
REQ-018 flags SHALL load flags_in at the rising edge when instr_valid & flag_we & cond_ex; otherwise hold.
REQ-019 The stack SHALL be LIFO with an occupancy count 0..DEPTH; stk_empty = (count==0), stk_full = (count==DEPTH), both combinational from count.
REQ-020 push alone, not full: top entry SHALL receive the pre-edge value of flags, count +1, effective next edge.
REQ-021 pop alone, not empty: flags SHALL load the top entry, count -1, next edge.
REQ-022 push while full, or pop while empty: no change to stack, count, or flags from that request; stk_err SHALL be 1 for exactly the next cycle.
REQ-023 push and pop in the same cycle: both ignored, stk_err 1 next cycle; a simultaneous qualified flag update still applies.
REQ-024 pop and qualified flag update in the same cycle: pop SHALL take priority; flags_in is discarded.
REQ-025 push and qualified flag update in the same cycle: stack SHALL store pre-update flags; flags SHALL take flags_in.
REQ-026 push/pop SHALL act regardless of instr_valid and cond_ex.
REQ-027 stk_err SHALL be 0 in any cycle not following an error condition.

Reset
REQ-028 reset_n low SHALL immediately force flags=4'b0000, count=0, stk_err=0, regardless of clk.
REQ-029 Stack entry contents are don't-care after reset; reads only occur via pop with count>0.
REQ-030 After reset with cond=0, cond_ex SHALL be 0 (Z=0); with cond=14, cond_ex=1 and gated enables follow inputs.
REQ-031 Reset deassertion mid-push/pop SHALL leave state at reset values until the first edge with reset_n high.

Verification
REQ-032 Update: flags_in=4'b0100, cond=14, flag_we=1, instr_valid=1 -> next cycle flags=0100; cond=0 gives cond_ex=1; cond=1 gives 0.
REQ-033 Gating: flags=1001 (N,V set), cond=10, reg_we_in=1 -> reg_we=1; cond=11 -> reg_we=0, and a flag_we in that cycle leaves flags unchanged.
REQ-034 Condition sweep: all 16 flag values x 16 cond codes -> cond_ex matches REQ-016 table.
REQ-035 Stack, DEPTH=2: push with flags=0001, then 0010, third push -> stk_full=1, stk_err pulses one cycle, count stays 2; two pops -> flags 0010 then 0001, stk_empty=1; third pop -> stk_err pulse, flags hold 0001.
REQ-036 Collisions: push+pop together -> stk_err, count unchanged; pop + qualified update with flags_in=1111 -> flags = popped value; push + update -> stored entry = old flags, flags=new.
REQ-037 Async reset: assert reset_n low between edges with count=1, flags=1010 -> flags=0000, stk_empty=1 before the next edge.
